// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared types and helpers for the pipeline hazard controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_tag_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when the stage will commit a real write to register src.
    function automatic logic tag_writes(input stage_tag_t t, input logic [4:0] src);
        return t.valid && t.regwrite && (t.rd != REG_ZERO) && (t.rd == src);
    endfunction

    function automatic fwd_sel_e pick_fwd(input logic uses, input stage_tag_t mem_t,
                                          input stage_tag_t wb_t, input logic [4:0] src);
        if (uses && tag_writes(mem_t, src))
            return FWD_EXMEM;
        else if (uses && tag_writes(wb_t, src))
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stage_tag_reg.sv
// ============================================================================
// stage_tag_reg : one pipeline tag record with hold, bubble and async clear
// Revision      : 1.0
// ============================================================================
`default_nettype none

module stage_tag_reg
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       bubble,
    input  stage_tag_t d,
    output stage_tag_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (!hold)
            q <= bubble ? '0 : d;
    end

endmodule

`default_nettype wire

// File: rtl/hazard_forward_unit.sv
// ============================================================================
// hazard_forward_unit : stall/flush/forward control for the 32x32 register file
// Optional macro HAZARD_STATS_EN adds stall/flush/freeze event counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_forward_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            ex_branch_taken,
    input  logic            mem_busy,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_bubble,
    output logic            ifid_flush,
    output logic [1:0]      ex_fwd_a,
    output logic [1:0]      ex_fwd_b,
    output logic            id_byp_a,
    output logic            id_byp_b,
    output logic            wb_regwrite,
    output logic [4:0]      wb_rd
`ifdef HAZARD_STATS_EN
    ,
    output logic [XLEN-1:0] stall_cnt,
    output logic [XLEN-1:0] flush_cnt,
    output logic [XLEN-1:0] freeze_cnt
`endif
);

    stage_tag_t w_id_tag;
    stage_tag_t r_ex;
    stage_tag_t r_mem;
    stage_tag_t r_wb;
    logic [4:0] r_ex_rs1;
    logic [4:0] r_ex_rs2;
    logic       r_ex_use1;
    logic       r_ex_use2;

    logic w_freeze;
    logic w_flush;
    logic w_load_use;
    logic w_stall;
    logic w_bubble;
    logic w_unused_memread;

    generate
        if (XLEN < 1) begin : g_xlen_check
            $error("XLEN must be at least 1");
        end
    endgenerate

    assign w_id_tag = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

    // Priority: freeze > flush > load-use stall.
    assign w_freeze   = mem_busy;
    assign w_flush    = !w_freeze && ex_branch_taken;
    assign w_load_use = r_ex.valid && r_ex.memread && (r_ex.rd != REG_ZERO) && id_valid &&
                        ((id_use_rs1 && (id_rs1 == r_ex.rd)) || (id_use_rs2 && (id_rs2 == r_ex.rd)));
    assign w_stall    = !w_freeze && !w_flush && w_load_use;
    assign w_bubble   = w_flush || w_stall;

    assign pc_en       = !(w_freeze || w_stall);
    assign ifid_en     = !(w_freeze || w_stall);
    assign idex_bubble = w_bubble;
    assign ifid_flush  = w_flush;

    stage_tag_reg u_ex_tag (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (w_freeze),
        .bubble (w_bubble),
        .d      (w_id_tag),
        .q      (r_ex)
    );

    stage_tag_reg u_mem_tag (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (w_freeze),
        .bubble (1'b0),
        .d      (r_ex),
        .q      (r_mem)
    );

    stage_tag_reg u_wb_tag (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (w_freeze),
        .bubble (1'b0),
        .d      (r_mem),
        .q      (r_wb)
    );

    // Source fields are cleared on a bubble so a NOP never requests forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rs1  <= REG_ZERO;
            r_ex_rs2  <= REG_ZERO;
            r_ex_use1 <= 1'b0;
            r_ex_use2 <= 1'b0;
        end else if (!w_freeze) begin
            r_ex_rs1  <= w_bubble ? REG_ZERO : id_rs1;
            r_ex_rs2  <= w_bubble ? REG_ZERO : id_rs2;
            r_ex_use1 <= w_bubble ? 1'b0 : id_use_rs1;
            r_ex_use2 <= w_bubble ? 1'b0 : id_use_rs2;
        end
    end

    assign ex_fwd_a = pick_fwd(r_ex_use1, r_mem, r_wb, r_ex_rs1);
    assign ex_fwd_b = pick_fwd(r_ex_use2, r_mem, r_wb, r_ex_rs2);

    assign wb_regwrite = r_wb.valid && r_wb.regwrite && (r_wb.rd != REG_ZERO);
    assign wb_rd       = r_wb.rd;
    assign id_byp_a    = wb_regwrite && (r_wb.rd == id_rs1);
    assign id_byp_b    = wb_regwrite && (r_wb.rd == id_rs2);

    assign w_unused_memread = r_wb.memread;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (w_stall)  stall_cnt  <= stall_cnt + 1'b1;
            if (w_flush)  flush_cnt  <= flush_cnt + 1'b1;
            if (w_freeze) freeze_cnt <= freeze_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
// ============================================================================
// tb_hazard_forward_unit : randomized + directed bench against a stage-list model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_forward_unit;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic ex_branch_taken, mem_busy;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic pc_en, ifid_en, idex_bubble, ifid_flush, id_byp_a, id_byp_b, wb_regwrite;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic [4:0] wb_rd;
`ifdef HAZARD_STATS_EN
    logic [XLEN-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

    hazard_forward_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v; bit [4:0] rd; bit rw; bit mr; bit [4:0] rs1; bit [4:0] rs2; bit u1; bit u2;
    } instr_t;

    typedef struct {
        instr_t ins; bit br; bit busy;
    } in_t;

    // Model pipe: index 0 = EX, 1 = MEM, 2 = WB.
    instr_t pipe[3];
    int unsigned m_stall, m_flush, m_freeze;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t nop();
        instr_t r = '{default: 0};
        return r;
    endfunction

    function automatic in_t mk(input instr_t i, input bit br, input bit busy);
        in_t x;
        x.ins = i; x.br = br; x.busy = busy;
        return x;
    endfunction

    function automatic instr_t op(input bit ld, input bit [4:0] rd, input bit [4:0] rs1,
                                  input bit [4:0] rs2, input bit u1, input bit u2);
        instr_t r;
        r.v = 1; r.rd = rd; r.rw = 1; r.mr = ld; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        return r;
    endfunction

    function automatic bit commits(input instr_t s, input bit [4:0] r);
        return s.v && s.rw && s.rd != 0 && s.rd == r;
    endfunction

    function automatic bit [1:0] model_fwd(input bit uses, input bit [4:0] r);
        if (uses && commits(pipe[1], r)) return 2'b01;
        if (uses && commits(pipe[2], r)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic apply(input in_t x);
        id_valid = x.ins.v; id_rs1 = x.ins.rs1; id_rs2 = x.ins.rs2;
        id_use_rs1 = x.ins.u1; id_use_rs2 = x.ins.u2; id_rd = x.ins.rd;
        id_regwrite = x.ins.rw; id_memread = x.ins.mr;
        ex_branch_taken = x.br; mem_busy = x.busy;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = nop();
        m_stall = 0; m_flush = 0; m_freeze = 0;
    endtask

    // Drive inputs at the negedge, compare, then move the model across the posedge.
    task automatic step(input in_t x);
        bit freeze, flush, lu, stall, wbw;
        apply(x);
        #1;
        freeze = x.busy;
        flush  = !freeze && x.br;
        lu     = x.ins.v && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
                 ((x.ins.u1 && x.ins.rs1 == pipe[0].rd) || (x.ins.u2 && x.ins.rs2 == pipe[0].rd));
        stall  = !freeze && !flush && lu;
        wbw    = pipe[2].v && pipe[2].rw && pipe[2].rd != 0;
        check("pc_en",       32'(pc_en),       32'(!(freeze || stall)));
        check("ifid_en",     32'(ifid_en),     32'(!(freeze || stall)));
        check("idex_bubble", 32'(idex_bubble), 32'(flush || stall));
        check("ifid_flush",  32'(ifid_flush),  32'(flush));
        check("ex_fwd_a",    32'(ex_fwd_a),    32'(model_fwd(pipe[0].u1, pipe[0].rs1)));
        check("ex_fwd_b",    32'(ex_fwd_b),    32'(model_fwd(pipe[0].u2, pipe[0].rs2)));
        check("wb_regwrite", 32'(wb_regwrite), 32'(wbw));
        check("wb_rd",       32'(wb_rd),       32'(pipe[2].rd));
        check("id_byp_a",    32'(id_byp_a),    32'(wbw && pipe[2].rd == x.ins.rs1));
        check("id_byp_b",    32'(id_byp_b),    32'(wbw && pipe[2].rd == x.ins.rs2));
`ifdef HAZARD_STATS_EN
        check("stall_cnt",  stall_cnt,  m_stall);
        check("flush_cnt",  flush_cnt,  m_flush);
        check("freeze_cnt", freeze_cnt, m_freeze);
`endif
        @(posedge clk);
        if (freeze) m_freeze++;
        if (flush)  m_flush++;
        if (stall)  m_stall++;
        if (!freeze) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (flush || stall) ? nop() : x.ins;
        end
        @(negedge clk);
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        r.v = ($urandom_range(0, 9) != 0);
        r.rd = 5'($urandom_range(0, 3)); r.rs1 = 5'($urandom_range(0, 3));
        r.rs2 = 5'($urandom_range(0, 3));
        r.rw = ($urandom_range(0, 3) != 0); r.mr = ($urandom_range(0, 9) < 4);
        r.u1 = ($urandom_range(0, 3) != 0); r.u2 = ($urandom_range(0, 1) != 0);
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        apply(mk(nop(), 0, 0));
        model_reset();
        #1;
        check("rst_pc_en", 32'(pc_en), 32'd1);
        check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(mk(nop(), 0, 0));

        // Load then dependent: one stall, then forward from WB.
        step(mk(op(1, 5, 0, 0, 0, 0), 0, 0));
        apply(mk(op(0, 6, 5, 0, 1, 0), 0, 0));
        #1 check("lu_stall_pc_en", 32'(pc_en), 32'd0);
        #1 check("lu_stall_bubble", 32'(idex_bubble), 32'd1);
        step(mk(op(0, 6, 5, 0, 1, 0), 0, 0));
        step(mk(op(0, 6, 5, 0, 1, 0), 0, 0));
        check("lu_fwd_wb", 32'(ex_fwd_a), 32'd2);
`ifdef HAZARD_STATS_EN
        check("lu_stall_cnt", stall_cnt, 32'd1);
`endif

        // ALU chain on x3 with WB also holding x3: MEM wins.
        step(mk(op(0, 3, 0, 0, 0, 0), 0, 0));
        step(mk(op(0, 3, 0, 0, 0, 0), 0, 0));
        step(mk(op(0, 8, 0, 3, 0, 1), 0, 0));
        check("alu_fwd_b_mem", 32'(ex_fwd_b), 32'd1);

        // x0 destination never stalls or forwards.
        step(mk(op(1, 0, 0, 0, 0, 0), 0, 0));
        apply(mk(op(0, 9, 0, 0, 1, 1), 0, 0));
        #1 check("x0_no_stall", 32'(pc_en), 32'd1);
        step(mk(op(0, 9, 0, 0, 1, 1), 0, 0));
        check("x0_fwd_a", 32'(ex_fwd_a), 32'd0);

        // Flush together with a load-use condition.
        step(mk(op(1, 4, 0, 0, 0, 0), 0, 0));
        apply(mk(op(0, 9, 4, 0, 1, 0), 1, 0));
        #1 check("flush_pc_en", 32'(pc_en), 32'd1);
        check("flush_ifid_flush", 32'(ifid_flush), 32'd1);
        step(mk(op(0, 9, 4, 0, 1, 0), 1, 0));

        // Freeze for 3 cycles with a pending forward, then release.
        step(mk(op(0, 2, 0, 0, 0, 0), 0, 0));
        step(mk(op(0, 10, 2, 0, 1, 0), 0, 0));
        for (int i = 0; i < 3; i++) begin
            step(mk(nop(), 0, 1));
            check("frz_fwd_hold", 32'(ex_fwd_a), 32'd1);
        end
        step(mk(nop(), 0, 0));

        // WB write to x7 seen by an ID read of x7.
        step(mk(op(0, 7, 0, 0, 0, 0), 0, 0));
        step(mk(nop(), 0, 0));
        step(mk(nop(), 0, 0));
        apply(mk(op(0, 11, 7, 0, 1, 0), 0, 0));
        #1 check("byp_a_x7", 32'(id_byp_a), 32'd1);
        step(mk(op(0, 11, 7, 0, 1, 0), 0, 0));

        // Reset in the middle of a stall discards every tag.
        step(mk(op(1, 5, 0, 0, 0, 0), 0, 0));
        apply(mk(op(0, 6, 5, 0, 1, 0), 0, 0));
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rst_mid_pc_en", 32'(pc_en), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(op(0, 6, 5, 0, 1, 0), 0, 0));

        for (int n = 0; n < 400; n++)
            step(mk(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline controller for the 32×32 register file in the segmented RISC-V core. Tracks destination tags for instructions in EX, MEM and WB, and drives the stall, flush and forwarding controls. These keep register-file reads coherent with in-flight writes. It sits beside the register file and pipeline registers and owns no datapath, only control.

## Interface
- `XLEN`, default 32: datapath width; used only by the statistics counters.
- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_valid` input 1: the decode stage holds a real instruction.
- `id_rs1`, `id_rs2` input 5 each: source registers being read from the register file this cycle.
- `id_use_rs1`, `id_use_rs2` input 1 each: the instruction actually consumes that source.
- `id_rd` input 5: destination register of the decode instruction.
- `id_regwrite` input 1: the decode instruction writes `id_rd`.
- `id_memread` input 1: the decode instruction is a load.
- `ex_branch_taken` input 1: a branch resolved taken in EX this cycle.
- `mem_busy` input 1: the data memory is not ready, so the whole pipe freezes.
- `pc_en`, `ifid_en` output 1 each: PC and IF/ID register update enables.
- `idex_bubble`, `ifid_flush` output 1 each: insert a NOP into ID/EX or IF/ID.
- `ex_fwd_a`, `ex_fwd_b` output 2 each: EX operand select. 00 = ID/EX register value, 01 = EX/MEM ALU result, 10 = MEM/WB write data.
- `id_byp_a`, `id_byp_b` output 1 each: replace the register file read at ID with the WB write data (same-cycle write/read bypass).
- `wb_regwrite` output 1: register file write enable, i.e. the WB tag is valid, regwrite is set and rd≠0.
- `wb_rd` output 5: register file write address.

## Operation
- **Internal tag pipeline.** Three stage records, EX, MEM and WB. Each holds {valid, rd, regwrite, memread}. EX additionally holds rs1, rs2, use_rs1 and use_rs2.
- **Normal advance** (no freeze, stall or flush): EX←ID inputs, MEM←EX, WB←MEM.
- **Load-use stall** is raised when all of the following hold:
  - EX.valid, EX.memread and EX.rd≠0;
  - id_valid;
  - (id_use_rs1 and id_rs1=EX.rd) or (id_use_rs2 and id_rs2=EX.rd).
- **Effect of a load-use stall:** pc_en=0, ifid_en=0, idex_bubble=1. EX is loaded with valid=0 while MEM and WB advance. The stall lasts exactly one cycle.
- **Flush** (`ex_branch_taken`): ifid_flush=1, idex_bubble=1. EX is loaded with valid=0, pc_en=1, and MEM/WB advance. Flush has priority over load-use stall.
- **Freeze** (`mem_busy`): pc_en=0, ifid_en=0, no bubble, no flush, and all tag records hold. Freeze has priority over flush and stall. Upstream holds `ex_branch_taken` until freeze drops.
- **EX forwarding (`ex_fwd_a`)** is decided by priority:
  - 01 if MEM.valid, MEM.regwrite, MEM.rd≠0, EX.use_rs1 and MEM.rd=EX.rs1;
  - else 10 if the same conditions hold against WB;
  - else 00.
  - `ex_fwd_b` uses rs2 in the same way. No forwarding to EX or from x0, ever.
- **ID bypass:** id_byp_a=1 when wb_regwrite is asserted and wb_rd=id_rs1. id_byp_b is the same with id_rs2.
- **Outputs without stall, flush or freeze:** pc_en=1, ifid_en=1, all other control outputs 0.

## Timing
- All tag records are flops and clear to valid=0 asynchronously on rst_n low.
- Outputs during and after reset: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0, fwd selects 00, byp 0, wb_regwrite=0, wb_rd=0.
- Every control output is combinational from the tag records plus the current ID inputs, with zero added latency, and is valid in the same cycle.
- Load→dependent: one stall cycle, then forward select 10 from WB.
- ALU→dependent: zero stall cycles, forward select 01.
- Reset asserted mid-stall discards all tags. The first cycle after release is a clean pipe.

## Configuration
- **`HAZARD_STATS_EN` defined:** adds outputs `stall_cnt`, `flush_cnt` and `freeze_cnt`, each `XLEN` bits wide.
  - Each increments once per cycle in which its condition wins priority.
  - Each wraps modulo 2^XLEN.
  - Each clears on rst_n.
- **`HAZARD_STATS_EN` undefined:** the ports and counters are absent and behaviour is otherwise identical.

## Structure
- **Shared package `pipe_ctrl_pkg`:**
  - enum `fwd_sel_e` {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10};
  - struct `stage_tag_t` {valid, rd[4:0], regwrite, memread};
  - constant `REG_ZERO=5'd0`.
- **Sub-module `stage_tag_reg`:** one instance per stage. It provides a tag flop with hold, bubble and async clear.

## Test plan
- **Load followed by ALU use:** `lw x5` in EX, ID reads rs1=x5 → one cycle of pc_en=0, ifid_en=0, idex_bubble=1. The next cycle has ex_fwd_a=10.
- **Back-to-back ALU dependency:** `add x3` in MEM, EX reads rs2=x3 → ex_fwd_b=01 with no stall. If WB also has rd=x3, the select is still 01.
- **x0 destination:** a load or ALU op writing x0 with a dependent reading x0 → no stall, fwd 00, wb_regwrite=0.
- **Flush and stall together:** ex_branch_taken with a load-use condition in the same cycle → ifid_flush=1, idex_bubble=1, pc_en=1.
- **Freeze with pending forward:** mem_busy held 3 cycles → tags unchanged, fwd selects stable, pc_en=0. Release resumes the correct forward.
- **WB/ID bypass:** WB writes x7=0xDEADBEEF while ID reads rs1=x7 → id_byp_a=1. With `HAZARD_STATS_EN`, stall_cnt=1 after the load-use scenario.
